// File: rtl/wash_pkg.sv
// Purpose: shared state encoding and per-program BCD duration table for the washer sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: state_e (also the PHASE encoding), dur_t, mode_dur(), state_dur(), is_timed().
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Two-digit BCD preset per timed state; every entry keeps both nibbles in 0..9.
  typedef struct packed {
    logic [7:0] fill;
    logic [7:0] wash;
    logic [7:0] drain;
    logic [7:0] rinse;
    logic [7:0] spin;
  } dur_t;

  function automatic dur_t mode_dur(input logic [1:0] mode);
    dur_t d;
    case (mode)
      2'd0:    d = '{fill: 8'h15, wash: 8'h31, drain: 8'h05, rinse: 8'h12, spin: 8'h20};
      2'd1:    d = '{fill: 8'h15, wash: 8'h45, drain: 8'h05, rinse: 8'h15, spin: 8'h30};
      2'd2:    d = '{fill: 8'h12, wash: 8'h20, drain: 8'h04, rinse: 8'h10, spin: 8'h10};
      default: d = '{fill: 8'h10, wash: 8'h09, drain: 8'h03, rinse: 8'h06, spin: 8'h40};
    endcase
    return d;
  endfunction

  function automatic logic [7:0] state_dur(input logic [1:0] mode, input state_e st);
    dur_t d;
    logic [7:0] r;
    d = mode_dur(mode);
    case (st)
      ST_FILL:  r = d.fill;
      ST_WASH:  r = d.wash;
      ST_DRAIN: r = d.drain;
      ST_RINSE: r = d.rinse;
      ST_SPIN:  r = d.spin;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

  // States whose exit is paced by the external timer's terminal count.
  function automatic logic is_timed(input state_e st);
    return (st == ST_FILL) || (st == ST_WASH) || (st == ST_DRAIN) ||
           (st == ST_RINSE) || (st == ST_SPIN);
  endfunction

endpackage

// File: rtl/motor_dir_gen.sv
// Purpose: alternates drum direction forward/reverse every DIR_PERIOD enabled cycles, starting forward.
// Latency: direction flips on the edge ending the DIR_PERIOD-th unfrozen enabled cycle.
// Backpressure: freeze_i holds the phase counter and blanks both outputs; dropping en_i resets to forward.
// Ports: clk_i, rst_ni (async active-low), en_i, freeze_i -> motor_f_o, motor_r_o (never both high).
module motor_dir_gen #(
  parameter int DIR_PERIOD = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic freeze_i,
  output logic motor_f_o,
  output logic motor_r_o
);

  localparam int            CW   = $clog2(DIR_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(DIR_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          dir_q;  // 0 = forward, 1 = reverse

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (!freeze_i) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        dir_q <= ~dir_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign motor_f_o = en_i & ~freeze_i & ~dir_q;
  assign motor_r_o = en_i & ~freeze_i &  dir_q;

endmodule

// File: rtl/wash_sequencer.sv
// Purpose: washer program FSM driving valve/pump/motor/lock/buzzer and presetting an external BCD timer.
// Latency: state changes one CP edge after START/QCC/ABORT is sampled; LOAD/RS appear in the new state's first cycle.
// Backpressure: PAUSE raises HOLD and blanks actuators in the same cycle; a QCC seen while paused is kept until release.
// Ports: CP, nCR, START, PAUSE, ABORT, MODE[1:0], QCC -> RS[7:0], LOAD, HOLD, VALVE, PUMP,
//        MOTOR_F, MOTOR_R, DOOR_LOCK, BUZZ, PHASE[2:0].
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int RINSE_CNT   = 2,
  parameter int DIR_PERIOD  = 16,
  parameter int BUZZ_CYCLES = 8
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       ABORT,
  input  logic [1:0] MODE,
  input  logic       QCC,
  output logic [7:0] RS,
  output logic       LOAD,
  output logic       HOLD,
  output logic       VALVE,
  output logic       PUMP,
  output logic       MOTOR_F,
  output logic       MOTOR_R,
  output logic       DOOR_LOCK,
  output logic       BUZZ,
  output logic [2:0] PHASE
);

  localparam int            BW         = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_CYCLES - 1);
  localparam logic [1:0]    RINSE_LAST = 2'(RINSE_CNT);

  state_e        state_q, state_d, nxt;
  logic          load_q, load_d;
  logic [7:0]    rs_q, rs_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    rinse_q, rinse_d;  // rinse passes started so far
  logic          pend_q, pend_d;    // QCC seen while paused
  logic          abort_q, abort_d;  // program cancelled: next DRAIN exit goes to IDLE
  logic [BW-1:0] buzz_q, buzz_d;
  logic          adv;
  logic          mf, mr;

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    rs_d    = rs_q;
    mode_d  = mode_q;
    rinse_d = rinse_q;
    pend_d  = pend_q;
    abort_d = abort_q;
    buzz_d  = buzz_q;
    adv     = 1'b0;
    nxt     = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d  = MODE;
          rinse_d = '0;
          pend_d  = 1'b0;
          abort_d = 1'b0;
          adv     = 1'b1;
          nxt     = ST_FILL;
        end
      end
      ST_DONE: begin
        if (buzz_q == BUZZ_LAST) begin
          state_d = ST_IDLE;
          buzz_d  = '0;
        end else begin
          buzz_d = buzz_q + BW'(1);
        end
      end
      default: begin
        // ABORT outranks PAUSE and QCC; inside DRAIN it only marks the run as cancelled.
        if (ABORT && (state_q != ST_DRAIN)) begin
          adv     = 1'b1;
          nxt     = ST_DRAIN;
          abort_d = 1'b1;
          pend_d  = 1'b0;
        end else begin
          if (ABORT) abort_d = 1'b1;
          // The LOAD cycle's QCC belongs to the previous count and is dropped.
          if (!load_q) begin
            if (PAUSE) begin
              if (QCC) pend_d = 1'b1;
            end else if (QCC || pend_q) begin
              pend_d = 1'b0;
              adv    = 1'b1;
              case (state_q)
                ST_FILL:           nxt = (rinse_q == 2'd0) ? ST_WASH : ST_RINSE;
                ST_WASH, ST_RINSE: nxt = ST_DRAIN;
                ST_DRAIN: begin
                  if (abort_q || ABORT) begin
                    nxt = ST_IDLE;
                  end else if (rinse_q < RINSE_LAST) begin
                    nxt     = ST_FILL;
                    rinse_d = rinse_q + 2'd1;
                  end else begin
                    nxt = ST_SPIN;
                  end
                end
                ST_SPIN: begin
                  nxt    = ST_DONE;
                  buzz_d = '0;
                end
                default: nxt = ST_IDLE;
              endcase
            end
          end
        end
      end
    endcase
    if (adv) begin
      state_d = nxt;
      if (is_timed(nxt)) begin
        load_d = 1'b1;
        rs_d   = state_dur(mode_d, nxt);
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      rs_q    <= 8'h00;
      mode_q  <= 2'd0;
      rinse_q <= 2'd0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      buzz_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      rs_q    <= rs_d;
      mode_q  <= mode_d;
      rinse_q <= rinse_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      buzz_q  <= buzz_d;
    end
  end

  motor_dir_gen #(.DIR_PERIOD(DIR_PERIOD)) u_motor_dir (
    .clk_i     (CP),
    .rst_ni    (nCR),
    .en_i      ((state_q == ST_WASH) || (state_q == ST_RINSE)),
    .freeze_i  (PAUSE),
    .motor_f_o (mf),
    .motor_r_o (mr)
  );

  // Actuators decode the registered state; PAUSE gating is combinational so the
  // timer and loads stop in the very cycle PAUSE is raised.
  assign HOLD      = is_timed(state_q) & PAUSE;
  assign VALVE     = (state_q == ST_FILL) & ~HOLD;
  assign PUMP      = ((state_q == ST_DRAIN) || (state_q == ST_SPIN)) & ~HOLD;
  assign MOTOR_F   = mf | ((state_q == ST_SPIN) & ~HOLD);
  assign MOTOR_R   = mr;
  assign DOOR_LOCK = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign BUZZ      = (state_q == ST_DONE);
  assign PHASE     = state_q;
  assign LOAD      = load_q;
  assign RS        = rs_q;

endmodule
